// File: rtl/mac_simd_pkg.sv
// Shared opcodes and width helpers for the scalar/SIMD multiply-accumulate unit.
package mac_simd_pkg;

    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_MAC  = 3'b010;
    localparam logic [2:0] OP_SAT  = 3'b011;
    localparam logic [2:0] OP_CLR2 = 3'b100;
    localparam logic [2:0] OP_SMUL = 3'b101;
    localparam logic [2:0] OP_SMAC = 3'b110;
    localparam logic [2:0] OP_SSAT = 3'b111;

    function automatic int lane_w(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

    function automatic int guard_lw(input int guard_w, input int lanes);
        return guard_w / lanes;
    endfunction

    function automatic int acc_w(input int data_w, input int guard_w);
        return guard_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/mac_simd_pipe_lane.sv
// One signed multiply / guard-extended accumulate / clamp slice; the top uses it
// for every SIMD lane and, at full width, for the scalar path.
module mac_lane #(
    parameter int LW = 8,
    parameter int GW = 4
) (
    input  logic [LW-1:0]      a,
    input  logic [LW-1:0]      b,
    input  logic [2*LW+GW-1:0] acc,
    output logic [2*LW+GW-1:0] mul_val,
    output logic [2*LW+GW-1:0] mac_val,
    output logic [2*LW+GW-1:0] sat_val,
    output logic               sat_hit
);

    localparam int SW = 2 * LW + GW;
    localparam logic signed [SW-1:0] MAX_V = {{(GW + 1){1'b0}}, {(2 * LW - 1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(GW + 1){1'b1}}, {(2 * LW - 1){1'b0}}};

    logic signed [2*LW-1:0] prod;
    logic                   over;
    logic                   under;

    // Most-negative squared still fits in 2*LW signed bits, so no product clamp is needed.
    assign prod    = $signed(a) * $signed(b);
    assign mul_val = {{GW{prod[2*LW-1]}}, prod};
    assign mac_val = acc + mul_val;

    assign over    = $signed(acc) > MAX_V;
    assign under   = $signed(acc) < MIN_V;
    assign sat_hit = over | under;
    assign sat_val = over ? MAX_V : (under ? MIN_V : acc);

endmodule

// File: rtl/mac_simd_pipe.sv
// Scalar/SIMD multiply-accumulate with guard bits, sticky saturation flags,
// an OUT_STAGES-deep output delay line and a whole-block stall.
module mac_simd_pipe
    import mac_simd_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int LANES      = 2,
    parameter int GUARD_W    = 8,
    parameter int OUT_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          instruction,
    input  logic [DATA_W-1:0]   multiplier,
    input  logic [DATA_W-1:0]   multiplicand,
    input  logic                stall,
    output logic [GUARD_W-1:0]  protect,
    output logic [2*DATA_W-1:0] result,
    output logic                out_valid,
    output logic [LANES-1:0]    sat_flag
);

    localparam int LW    = lane_w(DATA_W, LANES);
    localparam int GW    = guard_lw(GUARD_W, LANES);
    localparam int ACC_W = acc_w(DATA_W, GUARD_W);
    localparam int LSW   = 2 * LW + GW;

    logic [ACC_W-1:0]                  acc;
    logic [ACC_W-1:0]                  acc_next;
    logic                              acc_valid;
    logic [LANES-1:0]                  flag_next;
    logic [OUT_STAGES-1:0][ACC_W-1:0]  pipe_data;
    logic [OUT_STAGES-1:0]             pipe_valid;

    logic [ACC_W-1:0]                  scalar_mul;
    logic [ACC_W-1:0]                  scalar_mac;
    logic [ACC_W-1:0]                  scalar_sat;
    logic                              scalar_hit;

    logic [ACC_W-1:0]                  simd_mul;
    logic [ACC_W-1:0]                  simd_mac;
    logic [ACC_W-1:0]                  simd_sat;
    logic [LANES-1:0]                  lane_hit;

    mac_lane #(.LW(DATA_W), .GW(GUARD_W)) u_scalar (
        .a       (multiplier),
        .b       (multiplicand),
        .acc     (acc),
        .mul_val (scalar_mul),
        .mac_val (scalar_mac),
        .sat_val (scalar_sat),
        .sat_hit (scalar_hit)
    );

    // Lane i owns guard slice i and result slice i of the packed accumulator.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LSW-1:0] lane_acc;
        logic [LSW-1:0] lane_mul;
        logic [LSW-1:0] lane_mac;
        logic [LSW-1:0] lane_sat;

        assign lane_acc = {acc[2*DATA_W + i*GW +: GW], acc[i*2*LW +: 2*LW]};

        mac_lane #(.LW(LW), .GW(GW)) u_lane (
            .a       (multiplier[i*LW +: LW]),
            .b       (multiplicand[i*LW +: LW]),
            .acc     (lane_acc),
            .mul_val (lane_mul),
            .mac_val (lane_mac),
            .sat_val (lane_sat),
            .sat_hit (lane_hit[i])
        );

        assign simd_mul[i*2*LW +: 2*LW]        = lane_mul[2*LW-1:0];
        assign simd_mul[2*DATA_W + i*GW +: GW] = lane_mul[2*LW +: GW];
        assign simd_mac[i*2*LW +: 2*LW]        = lane_mac[2*LW-1:0];
        assign simd_mac[2*DATA_W + i*GW +: GW] = lane_mac[2*LW +: GW];
        assign simd_sat[i*2*LW +: 2*LW]        = lane_sat[2*LW-1:0];
        assign simd_sat[2*DATA_W + i*GW +: GW] = lane_sat[2*LW +: GW];
    end

    always_comb begin
        acc_next  = acc;
        flag_next = sat_flag;
        case (instruction)
            OP_CLR, OP_CLR2: begin
                acc_next  = '0;
                flag_next = '0;
            end
            OP_MUL:  acc_next = scalar_mul;
            OP_MAC:  acc_next = scalar_mac;
            OP_SAT: begin
                acc_next = scalar_sat;
                if (scalar_hit) flag_next[0] = 1'b1;
            end
            OP_SMUL: acc_next = simd_mul;
            OP_SMAC: acc_next = simd_mac;
            OP_SSAT: begin
                acc_next  = simd_sat;
                flag_next = sat_flag | lane_hit;
            end
            default: acc_next = acc;
        endcase
    end

    // The accumulator acts as the stage ahead of the delay line, so a word
    // accepted at edge k leaves the last stage after edge k+OUT_STAGES.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            acc_valid  <= 1'b0;
            sat_flag   <= '0;
            pipe_data  <= '0;
            pipe_valid <= '0;
        end else if (!stall) begin
            acc           <= acc_next;
            acc_valid     <= 1'b1;
            sat_flag      <= flag_next;
            pipe_data[0]  <= acc;
            pipe_valid[0] <= acc_valid;
            for (int s = 1; s < OUT_STAGES; s++) begin
                pipe_data[s]  <= pipe_data[s-1];
                pipe_valid[s] <= pipe_valid[s-1];
            end
        end
    end

    assign {protect, result} = pipe_data[OUT_STAGES-1];
    assign out_valid         = pipe_valid[OUT_STAGES-1];

endmodule

// File: tb/tb_mac_simd_pipe.sv
// Directed self-checking bench for mac_simd_pipe with default parameters.
module tb_mac_simd_pipe;
    import mac_simd_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [2:0]  instruction;
    logic [15:0] multiplier;
    logic [15:0] multiplicand;
    logic        stall;
    logic [7:0]  protect;
    logic [31:0] result;
    logic        out_valid;
    logic [1:0]  sat_flag;

    int checks = 0;
    int passed = 0;

    mac_simd_pipe dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instruction  (instruction),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .stall        (stall),
        .protect      (protect),
        .result       (result),
        .out_valid    (out_valid),
        .sat_flag     (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one instruction and sample 1 time unit after the edge that takes it.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        instruction  = op;
        multiplier   = a;
        multiplicand = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        stall = 1'b0;
        instruction = OP_CLR;
        multiplier = '0;
        multiplicand = '0;
        #2 reset_n = 1'b0;
        #10;
        checks++; if (result !== 32'h0) $display("[TB] FAIL reset_result: got %h expected %h", result, 32'h0); else passed++;
        checks++; if (protect !== 8'h0) $display("[TB] FAIL reset_protect: got %h expected %h", protect, 8'h0); else passed++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (sat_flag !== 2'b00) $display("[TB] FAIL reset_flag: got %b expected 00", sat_flag); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_scalar_mul;
        issue(OP_MUL, 16'hFFFE, 16'h0003);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mul_valid_e1: got %b expected 0", out_valid); else passed++;
        issue(OP_MAC, 16'h0000, 16'h0000);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mul_valid_e2: got %b expected 0", out_valid); else passed++;
        issue(OP_MAC, 16'h0000, 16'h0000);
        checks++; if ({protect, result} !== 40'hFF_FFFFFFFA) $display("[TB] FAIL mul_word: got %h expected %h", {protect, result}, 40'hFF_FFFFFFFA); else passed++;
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL mul_valid_e3: got %b expected 1", out_valid); else passed++;
    endtask

    task automatic test_scalar_sat;
        issue(OP_CLR, 16'h0000, 16'h0000);
        issue(OP_MUL, 16'h7FFF, 16'h7FFF);
        issue(OP_MAC, 16'h7FFF, 16'h7FFF);
        issue(OP_MAC, 16'h7FFF, 16'h7FFF);
        issue(OP_SAT, 16'h0000, 16'h0000);
        issue(OP_MAC, 16'h0000, 16'h0000);
        checks++; if ({protect, result} !== 40'h00_BFFD0003) $display("[TB] FAIL ssat_mac2: got %h expected %h", {protect, result}, 40'h00_BFFD0003); else passed++;
        issue(OP_MAC, 16'h0000, 16'h0000);
        checks++; if ({protect, result} !== 40'h00_7FFFFFFF) $display("[TB] FAIL ssat_word: got %h expected %h", {protect, result}, 40'h00_7FFFFFFF); else passed++;
        checks++; if (sat_flag !== 2'b01) $display("[TB] FAIL ssat_flag: got %b expected 01", sat_flag); else passed++;
        issue(OP_MUL, 16'h0001, 16'h0001);
        issue(OP_MAC, 16'h0000, 16'h0000);
        checks++; if (sat_flag !== 2'b01) $display("[TB] FAIL ssat_sticky: got %b expected 01", sat_flag); else passed++;
        issue(OP_CLR2, 16'h0000, 16'h0000);
        checks++; if (sat_flag !== 2'b00) $display("[TB] FAIL ssat_clear: got %b expected 00", sat_flag); else passed++;
    endtask

    task automatic test_neg_sat;
        issue(OP_CLR, 16'h0000, 16'h0000);
        issue(OP_MUL, 16'h8000, 16'h7FFF);
        issue(OP_MAC, 16'h8000, 16'h7FFF);
        issue(OP_MAC, 16'h8000, 16'h7FFF);
        checks++; if (sat_flag !== 2'b00) $display("[TB] FAIL neg_flag_pre: got %b expected 00", sat_flag); else passed++;
        issue(OP_SAT, 16'h0000, 16'h0000);
        issue(OP_MAC, 16'h0000, 16'h0000);
        checks++; if ({protect, result} !== 40'hFF_40018000) $display("[TB] FAIL neg_mac2: got %h expected %h", {protect, result}, 40'hFF_40018000); else passed++;
        issue(OP_MAC, 16'h0000, 16'h0000);
        checks++; if ({protect, result} !== 40'hFF_80000000) $display("[TB] FAIL neg_sat_word: got %h expected %h", {protect, result}, 40'hFF_80000000); else passed++;
        checks++; if (sat_flag !== 2'b01) $display("[TB] FAIL neg_sat_flag: got %b expected 01", sat_flag); else passed++;
    endtask

    task automatic test_min_product;
        issue(OP_CLR, 16'h0000, 16'h0000);
        issue(OP_MUL, 16'h8000, 16'h8000);
        issue(OP_SAT, 16'h0000, 16'h0000);
        issue(OP_MAC, 16'h0000, 16'h0000);
        checks++; if ({protect, result} !== 40'h00_40000000) $display("[TB] FAIL minprod_mul: got %h expected %h", {protect, result}, 40'h00_40000000); else passed++;
        issue(OP_MAC, 16'h0000, 16'h0000);
        checks++; if ({protect, result} !== 40'h00_40000000) $display("[TB] FAIL minprod_sat: got %h expected %h", {protect, result}, 40'h00_40000000); else passed++;
        checks++; if (sat_flag !== 2'b00) $display("[TB] FAIL minprod_flag: got %b expected 00", sat_flag); else passed++;
    endtask

    task automatic test_simd;
        issue(OP_CLR, 16'h0000, 16'h0000);
        issue(OP_SMUL, 16'h80FF, 16'h8002);
        issue(OP_SMAC, 16'h80FF, 16'h8002);
        issue(OP_SMAC, 16'h80FF, 16'h8002);
        checks++; if ({protect, result} !== 40'h0F_4000FFFE) $display("[TB] FAIL simd_mul: got %h expected %h", {protect, result}, 40'h0F_4000FFFE); else passed++;
        issue(OP_SSAT, 16'h0000, 16'h0000);
        checks++; if ({protect, result} !== 40'h0F_8000FFFC) $display("[TB] FAIL simd_mac1: got %h expected %h", {protect, result}, 40'h0F_8000FFFC); else passed++;
        issue(OP_SMAC, 16'h0000, 16'h0000);
        checks++; if ({protect, result} !== 40'h0F_C000FFFA) $display("[TB] FAIL simd_mac2: got %h expected %h", {protect, result}, 40'h0F_C000FFFA); else passed++;
        issue(OP_SMAC, 16'h0000, 16'h0000);
        checks++; if ({protect, result} !== 40'h0F_7FFFFFFA) $display("[TB] FAIL simd_sat: got %h expected %h", {protect, result}, 40'h0F_7FFFFFFA); else passed++;
        checks++; if (sat_flag !== 2'b10) $display("[TB] FAIL simd_flag: got %b expected 10", sat_flag); else passed++;
    endtask

    task automatic test_stall;
        logic [2:0] stall_ops [3];
        stall_ops[0] = OP_CLR;
        stall_ops[1] = OP_SMUL;
        stall_ops[2] = OP_SAT;
        issue(OP_CLR, 16'h0000, 16'h0000);
        issue(OP_MUL, 16'h0003, 16'h0004);
        issue(OP_MAC, 16'h0005, 16'h0006);
        issue(OP_MAC, 16'h0001, 16'h0002);
        checks++; if ({protect, result} !== 40'h00_0000000C) $display("[TB] FAIL stall_pre: got %h expected %h", {protect, result}, 40'h00_0000000C); else passed++;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(stall_ops[i], 16'h7FFF, 16'h7FFF);
            checks++; if ({protect, result} !== 40'h00_0000000C) $display("[TB] FAIL stall_hold_word: got %h expected %h", {protect, result}, 40'h00_0000000C); else passed++;
            checks++; if (out_valid !== 1'b1) $display("[TB] FAIL stall_hold_valid: got %b expected 1", out_valid); else passed++;
            checks++; if (sat_flag !== 2'b00) $display("[TB] FAIL stall_hold_flag: got %b expected 00", sat_flag); else passed++;
        end
        stall = 1'b0;
        issue(OP_MAC, 16'h0000, 16'h0000);
        checks++; if ({protect, result} !== 40'h00_0000002A) $display("[TB] FAIL stall_resume1: got %h expected %h", {protect, result}, 40'h00_0000002A); else passed++;
        issue(OP_MAC, 16'h0000, 16'h0000);
        checks++; if ({protect, result} !== 40'h00_0000002C) $display("[TB] FAIL stall_resume2: got %h expected %h", {protect, result}, 40'h00_0000002C); else passed++;
    endtask

    task automatic test_reset_mid;
        issue(OP_CLR, 16'h0000, 16'h0000);
        issue(OP_MUL, 16'h7FFF, 16'h7FFF);
        issue(OP_MAC, 16'h7FFF, 16'h7FFF);
        issue(OP_MAC, 16'h7FFF, 16'h7FFF);
        issue(OP_SAT, 16'h0000, 16'h0000);
        issue(OP_MUL, 16'h0010, 16'h0010);
        reset_n = 1'b0;
        #2;
        checks++; if ({protect, result} !== 40'h0) $display("[TB] FAIL rmid_word: got %h expected %h", {protect, result}, 40'h0); else passed++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rmid_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (sat_flag !== 2'b00) $display("[TB] FAIL rmid_flag: got %b expected 00", sat_flag); else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        issue(OP_MUL, 16'h0002, 16'h0003);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rmid_valid_e1: got %b expected 0", out_valid); else passed++;
        issue(OP_MAC, 16'h0000, 16'h0000);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rmid_valid_e2: got %b expected 0", out_valid); else passed++;
        issue(OP_MAC, 16'h0000, 16'h0000);
        checks++; if ({protect, result} !== 40'h00_00000006) $display("[TB] FAIL rmid_first: got %h expected %h", {protect, result}, 40'h00_00000006); else passed++;
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL rmid_valid_e3: got %b expected 1", out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_scalar_mul();
        test_scalar_sat();
        test_neg_sat();
        test_min_product();
        test_simd();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
